multi_digit_ssd_counter: RTL and testbench

//  Parametrised N-digit BCD up/down counter with a multiplexed seven-segment display driver.

---
 rtl/multi_digit_ssd_counter_if.sv | 27 ++
 rtl/multi_digit_ssd_counter.sv | 185 ++++++++++++++++++
 tb/tb_multi_digit_ssd_counter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_digit_ssd_counter_if.sv
// Bus bundle between board logic and the BCD counter / seven-segment display driver.
// The controller drives the counter controls; the counter returns its count and display signals.
interface multi_digit_ssd_counter_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic                    en;
  logic                    up;
  logic                    clr;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    wrap;
  logic [6:0]              segments;
  logic [NUM_DIGITS-1:0]   dig_sel;

  modport master (
    output en, up, clr, load, load_val,
    input  count, wrap, segments, dig_sel
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output count, wrap, segments, dig_sel
  );

endinterface

// File: rtl/multi_digit_ssd_counter.sv
// N-digit BCD up/down counter with a multiplexed seven-segment display driver.
// Digits ripple by BCD carry/borrow from one shared count prescaler. A free-running scan
// counter steps through digit positions; digit select and displayed nibble update together.
// Segments are active-high in {g,f,e,d,c,b,a} order.
module multi_digit_ssd_counter #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned SCAN_HZ    = 240,
  parameter bit          BLANK_LZ   = 1'b0
) (
  input logic                       clk,
  input logic                       rst,
  multi_digit_ssd_counter_if.slave  bus
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW       = 4 * NUM_DIGITS;

  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] DIG0_ON    = ~NUM_DIGITS'(1);

  // Segment_Selector: BCD nibble to {g,f,e,d,c,b,a}; non-BCD codes go dark.
  function automatic logic [6:0] segment_selector(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // Count path state
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CW-1:0]      count_q, count_d;
  logic               wrap_q, wrap_d;
  logic               tick;
  logic [CW-1:0]      count_step;
  logic [CW-1:0]      load_clean;
  logic               all_nine;
  logic               all_zero;
  logic               ripple;

  // Scan path state
  logic [SCAN_W-1:0]     scan_q, scan_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      idx_nxt;
  logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
  logic [3:0]            disp_q, disp_d;
  logic [3:0]            disp_nxt;
  logic                  lz;
  logic                  blank;

  // BCD ripple step, load sanitising and extreme-value detection
  always_comb begin
    count_step = count_q;
    load_clean = '0;
    all_nine   = 1'b1;
    all_zero   = 1'b1;
    ripple     = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      logic [3:0] dig;
      logic [3:0] lv;
      dig = count_q[4*i +: 4];
      lv  = bus.load_val[4*i +: 4];
      // A digit steps only while every lower digit sits at its terminal value.
      if (ripple) begin
        if (bus.up) begin
          count_step[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
          ripple = (dig == 4'd9);
        end else begin
          count_step[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
          ripple = (dig == 4'd0);
        end
      end
      load_clean[4*i +: 4] = (lv > 4'd9) ? 4'd0 : lv;
      all_nine = all_nine && (dig == 4'd9);
      all_zero = all_zero && (dig == 4'd0);
    end
  end

  // Next-state for prescaler, count and wrap: clr > load > tick
  always_comb begin
    tick    = bus.en && (presc_q == PRESC_LAST);
    presc_d = presc_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      presc_d = '0;
      count_d = '0;
    end else if (bus.load) begin
      presc_d = '0;
      count_d = load_clean;
    end else if (bus.en) begin
      if (tick) begin
        presc_d = '0;
        count_d = count_step;
        wrap_d  = bus.up ? all_nine : all_zero;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  // Count path registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next digit position, its nibble, and whether it is a blanked leading zero
  always_comb begin
    idx_nxt  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    disp_nxt = '0;
    lz       = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        disp_nxt = count_q[4*i +: 4];
      end
      if ((IDX_W'(i) >= idx_nxt) && (count_q[4*i +: 4] != 4'd0)) begin
        lz = 1'b0;
      end
    end
    blank = BLANK_LZ && (idx_nxt != '0) && lz;
  end

  // Scan next-state: select and nibble only move on the switch edge
  always_comb begin
    scan_d    = scan_q;
    idx_d     = idx_q;
    dig_sel_d = dig_sel_q;
    disp_d    = disp_q;
    if (scan_q == SCAN_LAST) begin
      scan_d    = '0;
      idx_d     = idx_nxt;
      disp_d    = disp_nxt;
      dig_sel_d = blank ? '1 : ~(NUM_DIGITS'(1) << idx_nxt);
    end else begin
      scan_d = scan_q + 1'b1;
    end
  end

  // Scan path registers; independent of en, clr and load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= '0;
      idx_q     <= '0;
      dig_sel_q <= DIG0_ON;
      disp_q    <= '0;
    end else begin
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dig_sel_q <= dig_sel_d;
      disp_q    <= disp_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.dig_sel  = dig_sel_q;
  assign bus.segments = segment_selector(disp_q);

endmodule

// File: tb/tb_multi_digit_ssd_counter.sv
// Directed bench for multi_digit_ssd_counter: 3 digits, TICK_DIV=10, SCAN_DIV=2.
// dut0 has no blanking, dut1 blanks leading zeros; both share the same stimulus.
module tb_multi_digit_ssd_counter;

  localparam int unsigned ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_digit_ssd_counter_if #(.NUM_DIGITS(ND)) bus0 ();
  multi_digit_ssd_counter_if #(.NUM_DIGITS(ND)) bus1 ();

  assign bus1.en       = bus0.en;
  assign bus1.up       = bus0.up;
  assign bus1.clr      = bus0.clr;
  assign bus1.load     = bus0.load;
  assign bus1.load_val = bus0.load_val;

  multi_digit_ssd_counter #(
    .NUM_DIGITS(ND), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .BLANK_LZ(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  multi_digit_ssd_counter #(
    .NUM_DIGITS(ND), .CLK_HZ(100), .TICK_HZ(10), .SCAN_HZ(50), .BLANK_LZ(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  typedef struct {
    string       name;
    logic        en;
    logic        up;
    logic        clr;
    logic        load;
    logic [11:0] lval;
    int          ncyc;
    logic [11:0] exp_count;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input string name, input logic en, input logic up,
                              input logic clr, input logic load, input logic [11:0] lval,
                              input int ncyc, input logic [11:0] exp_count,
                              input logic exp_wrap);
    vec_t v;
    v.name = name; v.en = en; v.up = up; v.clr = clr; v.load = load; v.lval = lval;
    v.ncyc = ncyc; v.exp_count = exp_count; v.exp_wrap = exp_wrap;
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic up, input logic clr, input logic load,
                       input logic [11:0] lval);
    bus0.en = en; bus0.up = up; bus0.clr = clr; bus0.load = load; bus0.load_val = lval;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Restart from reset with val loaded on edge 1, then check 6 edges of scanning.
  // Patterns are packed {edge6, ..., edge1}; nibble F means "blanked, segments unchecked".
  task automatic scan_case(input string name, input logic [11:0] val,
                           input logic [5:0][2:0] ds0, input logic [5:0][3:0] n0,
                           input logic [5:0][2:0] ds1, input logic [5:0][3:0] n1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, val);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (k == 0) bus0.load = 1'b0;
      check({name, "_dig_sel0"}, 32'(bus0.dig_sel), 32'(ds0[k]));
      check({name, "_seg0"}, 32'(bus0.segments), 32'(seg_of(n0[k])));
      check({name, "_dig_sel1"}, 32'(bus1.dig_sel), 32'(ds1[k]));
      if (n1[k] != 4'hF) check({name, "_seg1"}, 32'(bus1.segments), 32'(seg_of(n1[k])));
    end
  endtask

  localparam logic [5:0][2:0] DS_RUN = {3'b110, 3'b011, 3'b011, 3'b101, 3'b101, 3'b110};
  localparam logic [5:0][2:0] DS_BLK = {3'b110, 3'b111, 3'b111, 3'b111, 3'b111, 3'b110};

  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);

    // Count/wrap table; prescaler starts at 0 when reset releases.
    vecs.push_back(mk("up_99clk",     1, 1, 0, 0, 12'h000, 99, 12'h009, 0));
    vecs.push_back(mk("up_carry",     1, 1, 0, 0, 12'h000,  1, 12'h010, 0));
    vecs.push_back(mk("up_part",      1, 1, 0, 0, 12'h000,  5, 12'h010, 0));
    vecs.push_back(mk("en_low_hold",  0, 1, 0, 0, 12'h000,  7, 12'h010, 0));
    vecs.push_back(mk("resume_4",     1, 1, 0, 0, 12'h000,  4, 12'h010, 0));
    vecs.push_back(mk("resume_tick",  1, 1, 0, 0, 12'h000,  1, 12'h011, 0));
    vecs.push_back(mk("load_999",     1, 1, 0, 1, 12'h999,  1, 12'h999, 0));
    vecs.push_back(mk("pre_wrap",     1, 1, 0, 0, 12'h000,  9, 12'h999, 0));
    vecs.push_back(mk("wrap_up",      1, 1, 0, 0, 12'h000,  1, 12'h000, 1));
    vecs.push_back(mk("wrap_up_end",  1, 1, 0, 0, 12'h000,  1, 12'h000, 0));
    vecs.push_back(mk("load_099",     1, 1, 0, 1, 12'h099,  1, 12'h099, 0));
    vecs.push_back(mk("carry_2dig",   1, 1, 0, 0, 12'h000, 10, 12'h100, 0));
    vecs.push_back(mk("clr",          1, 0, 1, 0, 12'h000,  1, 12'h000, 0));
    vecs.push_back(mk("pre_wrap_dn",  1, 0, 0, 0, 12'h000,  9, 12'h000, 0));
    vecs.push_back(mk("wrap_dn",      1, 0, 0, 0, 12'h000,  1, 12'h999, 1));
    vecs.push_back(mk("wrap_dn_end",  1, 0, 0, 0, 12'h000,  1, 12'h999, 0));
    vecs.push_back(mk("down_998",     1, 0, 0, 0, 12'h000,  9, 12'h998, 0));
    vecs.push_back(mk("load_1A5",     0, 1, 0, 1, 12'h1A5,  1, 12'h105, 0));
    vecs.push_back(mk("clr_and_load", 0, 1, 1, 1, 12'h777,  1, 12'h000, 0));
    vecs.push_back(mk("pre_ld_tick",  1, 1, 0, 0, 12'h000,  9, 12'h000, 0));
    vecs.push_back(mk("load_on_tick", 1, 1, 0, 1, 12'h456,  1, 12'h456, 0));
    vecs.push_back(mk("after_load",   1, 1, 0, 0, 12'h000, 10, 12'h457, 0));
    vecs.push_back(mk("load_999b",    1, 1, 0, 1, 12'h999,  1, 12'h999, 0));
    vecs.push_back(mk("pre_ld_wrap",  1, 1, 0, 0, 12'h000,  9, 12'h999, 0));
    vecs.push_back(mk("ld_at_wrap",   1, 1, 0, 1, 12'h999,  1, 12'h999, 0));
    vecs.push_back(mk("pre_clr_wrap", 1, 1, 0, 0, 12'h000,  9, 12'h999, 0));
    vecs.push_back(mk("clr_at_wrap",  1, 1, 1, 0, 12'h000,  1, 12'h000, 0));
    vecs.push_back(mk("load_100",     1, 0, 0, 1, 12'h100,  1, 12'h100, 0));
    vecs.push_back(mk("borrow_2dig",  1, 0, 0, 0, 12'h000, 10, 12'h099, 0));

    // Reset state
    step(2);
    check("rst_count", 32'(bus0.count), 32'h000);
    check("rst_wrap", 32'(bus0.wrap), 32'h0);
    check("rst_dig_sel", 32'(bus0.dig_sel), 32'b110);
    check("rst_segments", 32'(bus0.segments), 32'h3F);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].load, vecs[i].lval);
      step(vecs[i].ncyc);
      check({vecs[i].name, "_count"}, 32'(bus0.count), 32'(vecs[i].exp_count));
      check({vecs[i].name, "_wrap"}, 32'(bus0.wrap), 32'(vecs[i].exp_wrap));
    end

    // Asynchronous reset mid-count at 0x047, while a digit other than 0 is selected
    drive(1'b0, 1'b1, 1'b0, 1'b1, 12'h047);
    step(1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
    for (int k = 0; k < 4 && bus0.dig_sel == 3'b110; k++) step(1);
    check("pre_rst_count", 32'(bus0.count), 32'h047);
    check("pre_rst_dig_sel_moved", 32'(bus0.dig_sel != 3'b110), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_count", 32'(bus0.count), 32'h000);
    check("async_rst_wrap", 32'(bus0.wrap), 32'h0);
    check("async_rst_dig_sel", 32'(bus0.dig_sel), 32'b110);
    check("async_rst_segments", 32'(bus0.segments), 32'h3F);
    #1;
    rst = 1'b0;
    // Prescaler restarts from 0: first tick needs a full 10 clocks
    step(9);
    check("post_rst_no_tick", 32'(bus0.count), 32'h000);
    step(1);
    check("post_rst_tick", 32'(bus0.count), 32'h001);

    // Display scanning and leading-zero blanking
    scan_case("scan_123", 12'h123, DS_RUN, {4'd3, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0},
              DS_RUN, {4'd3, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0});
    scan_case("scan_005", 12'h005, DS_RUN, {4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
              DS_BLK, {4'd5, 4'hF, 4'hF, 4'hF, 4'hF, 4'd0});
    scan_case("scan_000", 12'h000, DS_RUN, {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
              DS_BLK, {4'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'd0});
    scan_case("scan_050", 12'h050, DS_RUN, {4'd0, 4'd0, 4'd0, 4'd5, 4'd5, 4'd0},
              {3'b110, 3'b111, 3'b111, 3'b101, 3'b101, 3'b110},
              {4'd0, 4'hF, 4'hF, 4'd5, 4'd5, 4'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
